// File: rtl/calc_sequencer.sv
// calc_sequencer: debounced button sequencer driving a start/done ALU.
// Optional CALC_CHAIN_EN: C in S_SHOW chains the previous result into A.
module calc_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic [15:0] sw,
    input  logic        btnC,
    input  logic        btnL,
    input  logic        btnR,
    input  logic        btnD,
    input  logic        btnU,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [1:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    input  logic        alu_err,
    output logic [15:0] LED,
    output logic        busy
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_A,
        S_B,
        S_OP,
        S_RUN,
        S_SHOW,
        S_ERR
    } state_t;

    state_t r_state, w_nxt_state;

    logic [4:0] w_btn;
    logic [4:0] r_sync1, r_sync2;
    logic [4:0] w_evt;

    assign w_btn = {btnC, btnL, btnR, btnD, btnU};

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Event fires on the debounced release (1->0) of each button
    for (genvar i = 0; i < 5; i++) begin : g_db
        logic [DBW-1:0] r_cnt;
        logic           r_deb;
        logic           r_evt;

        always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
            if (!CPU_RESETN) begin
                r_cnt <= '0;
                r_deb <= 1'b0;
                r_evt <= 1'b0;
            end else begin
                r_evt <= 1'b0;
                if (r_sync2[i] == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == DB_LAST) begin
                    r_cnt <= '0;
                    r_deb <= r_sync2[i];
                    r_evt <= r_deb;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_evt[i] = r_evt;
    end

    logic       w_c_evt;
    logic       w_op_evt;
    logic [1:0] w_op_code;

    always_comb begin
        w_c_evt   = w_evt[4];
        w_op_evt  = 1'b0;
        w_op_code = 2'd0;
        if (!w_evt[4]) begin
            if (w_evt[3]) begin
                w_op_evt  = 1'b1;
                w_op_code = 2'd0;
            end else if (w_evt[2]) begin
                w_op_evt  = 1'b1;
                w_op_code = 2'd1;
            end else if (w_evt[1]) begin
                w_op_evt  = 1'b1;
                w_op_code = 2'd2;
            end else if (w_evt[0]) begin
                w_op_evt  = 1'b1;
                w_op_code = 2'd3;
            end
        end
    end

    logic [15:0]    r_led, r_alu_a, r_alu_b;
    logic [1:0]     r_alu_op;
    logic           r_alu_start;
    logic [TOW-1:0] r_to_cnt;
    logic [15:0]    w_nxt_led, w_nxt_a, w_nxt_b;
    logic [1:0]     w_nxt_op;
    logic           w_nxt_start;
    logic           w_launch;
`ifdef CALC_CHAIN_EN
    logic [15:0]    r_res, w_nxt_res;
`endif

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_led   = r_led;
        w_nxt_a     = r_alu_a;
        w_nxt_b     = r_alu_b;
        w_nxt_op    = r_alu_op;
        w_nxt_start = 1'b0;
        w_launch    = 1'b0;
`ifdef CALC_CHAIN_EN
        w_nxt_res   = r_res;
`endif
        unique case (r_state)
            S_A: begin
                if (w_c_evt) begin
                    w_nxt_a     = sw;
                    w_nxt_led   = sw;
                    w_nxt_state = S_B;
                end
            end
            S_B: begin
                if (w_c_evt) begin
                    w_nxt_b     = sw;
                    w_nxt_led   = sw;
                    w_nxt_state = S_OP;
                end
            end
            S_OP: begin
                if (w_c_evt) begin
                    w_nxt_a     = sw;
                    w_nxt_led   = sw;
                    w_nxt_state = S_B;
                end else begin
                    w_launch = w_op_evt;
                end
            end
            S_RUN: begin
                // done is not valid during the start cycle itself
                if (!r_alu_start && alu_done) begin
                    if (alu_err) begin
                        w_nxt_led   = 16'hFFFF;
                        w_nxt_state = S_ERR;
                    end else begin
                        w_nxt_led   = alu_result;
`ifdef CALC_CHAIN_EN
                        w_nxt_res   = alu_result;
`endif
                        w_nxt_state = S_SHOW;
                    end
                end else if (r_to_cnt == TO_LAST) begin
                    w_nxt_led   = 16'hFFFF;
                    w_nxt_state = S_ERR;
                end
            end
            S_SHOW: begin
                if (w_c_evt) begin
`ifdef CALC_CHAIN_EN
                    w_nxt_a     = r_res;
                    w_nxt_b     = sw;
                    w_nxt_led   = sw;
                    w_nxt_state = S_OP;
`else
                    w_nxt_a     = sw;
                    w_nxt_led   = sw;
                    w_nxt_state = S_B;
`endif
                end else begin
                    w_launch = w_op_evt;
                end
            end
            S_ERR: begin
                if (w_c_evt) begin
                    w_nxt_a     = sw;
                    w_nxt_led   = sw;
                    w_nxt_state = S_B;
                end
            end
            default: w_nxt_state = S_A;
        endcase
        if (w_launch) begin
            w_nxt_op = w_op_code;
            if (w_op_code == 2'd3 && r_alu_b == 16'd0) begin
                w_nxt_led   = 16'hFFFF;
                w_nxt_state = S_ERR;
            end else begin
                w_nxt_start = 1'b1;
                w_nxt_state = S_RUN;
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state <= S_A;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_led       <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_alu_start <= 1'b0;
            r_to_cnt    <= '0;
`ifdef CALC_CHAIN_EN
            r_res       <= '0;
`endif
        end else begin
            r_led       <= w_nxt_led;
            r_alu_a     <= w_nxt_a;
            r_alu_b     <= w_nxt_b;
            r_alu_op    <= w_nxt_op;
            r_alu_start <= w_nxt_start;
            r_to_cnt    <= (r_state == S_RUN) ? r_to_cnt + 1'b1 : '0;
`ifdef CALC_CHAIN_EN
            r_res       <= w_nxt_res;
`endif
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign alu_start = r_alu_start;
    assign LED       = r_led;
    assign busy      = (r_state == S_RUN);

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: vector table plus scoreboarded ALU handshakes.
// Works with or without CALC_CHAIN_EN defined.
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sw;
    logic        btnC, btnL, btnR, btnD, btnU;
    logic [15:0] alu_a, alu_b, alu_result, LED;
    logic [1:0]  alu_op;
    logic        alu_start, alu_done, alu_err, busy;

    always #5 clk = ~clk;

    calc_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .sw        (sw),
        .btnC      (btnC),
        .btnL      (btnL),
        .btnR      (btnR),
        .btnD      (btnD),
        .btnU      (btnU),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_start (alu_start),
        .alu_done  (alu_done),
        .alu_result(alu_result),
        .alu_err   (alu_err),
        .LED       (LED),
        .busy      (busy)
    );

    typedef struct {
        logic        ld_b;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic [15:0] exp;
    } vec_t;

    vec_t        tbl [5];
    logic [33:0] start_q [$];
    logic [15:0] res_q [$];
    int          n_cmp = 0;
    int          n_err = 0;

    logic        pend = 1'b0;
    logic        hang = 1'b0;
    logic        inject = 1'b0;
    logic        late_mode = 1'b0;
    int          cd = 0;
    logic [15:0] m_a, m_b;
    logic [1:0]  m_op;
    logic [31:0] prod;
    logic [33:0] exp_s;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor followed by a 3-cycle ALU model
    always @(negedge clk) begin
        if (pend) begin
            if (late_mode) begin
                chk("late_done_led", LED, 16'hFFFF);
            end else if (res_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got LED %0h expected none", LED);
            end else begin
                chk("result_led", LED, res_q.pop_front());
            end
        end
        pend = alu_done;
        if (alu_start) begin
            n_cmp++;
            if (start_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_start: got %0h/%0h/%0h expected none",
                         alu_a, alu_b, alu_op);
            end else begin
                exp_s = start_q.pop_front();
                if ({alu_a, alu_b, alu_op} !== exp_s) begin
                    n_err++;
                    $display("FAIL start_operands: got %0h expected %0h",
                             {alu_a, alu_b, alu_op}, exp_s);
                end
            end
        end
        alu_done = 1'b0;
        alu_err  = 1'b0;
        if (inject) begin
            alu_done   = 1'b1;
            alu_result = 16'h5555;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                alu_done = 1'b1;
                prod     = m_a * m_b;
                case (m_op)
                    2'd0: alu_result = m_a + m_b;
                    2'd1: alu_result = m_a - m_b;
                    2'd2: alu_result = prod[15:0];
                    default: begin
                        alu_err    = (m_b == 16'd0);
                        alu_result = (m_b == 16'd0) ? 16'd0 : m_a / m_b;
                    end
                endcase
            end
        end
        if (alu_start && !hang) begin
            cd   = 3;
            m_a  = alu_a;
            m_b  = alu_b;
            m_op = alu_op;
        end
    end

    task automatic set_btn(input logic [4:0] m);
        {btnC, btnL, btnR, btnD, btnU} = m;
    endtask

    task automatic press(input logic [4:0] m);
        @(negedge clk);
        set_btn(m);
        repeat (10) @(negedge clk);
        set_btn(5'b0);
        repeat (20) @(negedge clk);
    endtask

    task automatic load_c(input logic [15:0] v, input string nm);
        sw = v;
        press(5'b10000);
        chk(nm, LED, v);
    endtask

    task automatic push_op(input logic [15:0] a, input logic [15:0] b,
                           input logic [1:0] op, input logic [15:0] r);
        start_q.push_back({a, b, op});
        res_q.push_back(r);
    endtask

    task automatic wait_busy(input string nm);
        int n;
        n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 16'(busy), 16'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ea, eb;
        int n;
        tbl[0] = '{1'b1, 16'd7, 16'd5, 2'd0, 16'h000C};
        tbl[1] = '{1'b0, 16'd7, 16'd5, 2'd1, 16'h0002};
        tbl[2] = '{1'b0, 16'd7, 16'd5, 2'd2, 16'h0023};
        tbl[3] = '{1'b0, 16'd7, 16'd5, 2'd3, 16'h0001};
        tbl[4] = '{1'b0, 16'd7, 16'd5, 2'd0, 16'h000C};

        rst_n      = 1'b0;
        sw         = 16'd0;
        alu_done   = 1'b0;
        alu_err    = 1'b0;
        alu_result = 16'd0;
        set_btn(5'b0);
        repeat (3) @(negedge clk);
        chk("rst_led", LED, 16'd0);
        chk("rst_a", alu_a, 16'd0);
        chk("rst_b", alu_b, 16'd0);
        chk("rst_op", 16'(alu_op), 16'd0);
        chk("rst_start", 16'(alu_start), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        rst_n = 1'b1;

        // Short low glitch while C is held must not count as a release
        sw = 16'd7;
        @(negedge clk);
        btnC = 1'b1;
        repeat (10) @(negedge clk);
        btnC = 1'b0;
        repeat (2) @(negedge clk);
        btnC = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_no_event", LED, 16'd0);
        btnC = 1'b0;
        repeat (20) @(negedge clk);
        chk("load_a", LED, 16'd7);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].ld_b) load_c(tbl[i].b, "load_b");
            push_op(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp);
            press(5'b01000 >> tbl[i].op);
            chk($sformatf("vec%0d_led", i), LED, tbl[i].exp);
        end

`ifdef CALC_CHAIN_EN
        load_c(16'd2, "chain_b");
        push_op(16'h000C, 16'd2, 2'd2, 16'h0018);
        press(5'b00010);
        chk("chain_mul", LED, 16'h0018);
        load_c(16'd0, "chain_b0");
        press(5'b00001);
        chk("chain_div0", LED, 16'hFFFF);
        load_c(16'h0010, "err_to_b");
`else
        load_c(16'h0010, "show_to_b");
`endif
        load_c(16'd0, "b_zero");
        press(5'b00001);
        chk("div0_led", LED, 16'hFFFF);
        load_c(16'd3, "err_new_a");
        load_c(16'd4, "b_after_err");
        push_op(16'd3, 16'd4, 2'd0, 16'd7);
        press(5'b01000);
        chk("add_after_err", LED, 16'd7);

        // L and C released together: only C is taken
        sw = 16'd9;
        press(5'b11000);
        chk("prio_c_led", LED, 16'd9);
`ifdef CALC_CHAIN_EN
        push_op(16'd7, 16'd9, 2'd1, 16'hFFFE);
        ea = 16'd7;
        eb = 16'd9;
`else
        load_c(16'd2, "prio_b");
        push_op(16'd9, 16'd2, 2'd1, 16'd7);
        ea = 16'd9;
        eb = 16'd2;
`endif
        press(5'b00100);

        hang = 1'b1;
        start_q.push_back({ea, eb, 2'd0});
        @(negedge clk);
        set_btn(5'b01000);
        repeat (10) @(negedge clk);
        set_btn(5'b0);
        wait_busy("timeout_busy_up");
        n = 0;
        while (LED != 16'hFFFF && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", 16'(n), 16'd16);
        chk("timeout_busy_low", 16'(busy), 16'd0);
        hang = 1'b0;

        late_mode = 1'b1;
        @(negedge clk);
        #1 inject = 1'b1;
        @(negedge clk);
        #1 inject = 1'b0;
        repeat (4) @(negedge clk);
        late_mode = 1'b0;
        chk("late_led_hold", LED, 16'hFFFF);

        load_c(16'h0021, "rst_pre_a");
        load_c(16'h0022, "rst_pre_b");
        hang = 1'b1;
        start_q.push_back({16'h0021, 16'h0022, 2'd0});
        @(negedge clk);
        set_btn(5'b01000);
        repeat (10) @(negedge clk);
        set_btn(5'b0);
        wait_busy("abort_busy_up");
        chk("abort_start_pre", 16'(alu_start), 16'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_led", LED, 16'd0);
        chk("abort_start", 16'(alu_start), 16'd0);
        chk("abort_busy", 16'(busy), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hang  = 1'b0;
        load_c(16'h1234, "after_reset");

        repeat (5) @(negedge clk);
        chk("start_q_empty", 16'(start_q.size()), 16'd0);
        chk("res_q_empty", 16'(res_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Control FSM for the switch/button calculator datapath on the 100 MHz board.
- Debounces and edge-detects the five push-buttons.
- Sequences operand entry (A, then B) and operation select.
- Drives a multi-cycle ALU through a start/done handshake, then presents the result or an error code on the LEDs.
- Sits between the board I/O pins and the arithmetic unit. It owns all LED updates.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles a synchronized button level must stay stable before it is accepted (10 ms at 100 MHz).
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for alu_done before declaring an error.

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz.
- CPU_RESETN  in  1  asynchronous active-low reset.
- sw  in  16  operand switches.
- btnC  in  1  load operand (raw, asynchronous).
- btnL  in  1  select add.
- btnR  in  1  select subtract.
- btnD  in  1  select multiply.
- btnU  in  1  select divide.
- alu_a  out  16  operand A to ALU.
- alu_b  out  16  operand B to ALU.
- alu_op  out  2  opcode: 0 add, 1 sub, 2 mul, 3 div.
- alu_start  out  1  one-cycle start pulse.
- alu_done  in  1  ALU result valid; one-cycle pulse.
- alu_result  in  16  ALU result, valid with alu_done.
- alu_err  in  1  ALU error flag, valid with alu_done.
- LED  out  16  display.
- busy  out  1  high while in S_RUN.

Behaviour:
- Reset: CPU_RESETN low asynchronously clears everything.
  - State goes to S_A.
  - LED, alu_a, alu_b, alu_op, alu_start, busy, the debouncers and the timeout counter all clear to 0.
  - Reset mid-S_RUN aborts the operation; alu_start is forced low immediately.
- Button path, per button:
  - 2-FF synchronizer, then debouncer. The debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - An event is the debounced 1->0 transition (press-and-release). Each event lasts exactly one cycle.
- Simultaneous events in one cycle: only the highest-priority one is taken; the rest are discarded. Priority is C > L > R > D > U.
- S_A (wait operand A):
  - C: alu_a<=sw, LED<=sw, go to S_B.
  - Op events are ignored.
- S_B (wait operand B):
  - C: alu_b<=sw, LED<=sw, go to S_OP.
  - Op events are ignored.
- S_OP (operands loaded):
  - C: alu_a<=sw, LED<=sw, go to S_B (restart entry).
  - L/R/D/U: alu_op<=opcode, then:
    - If op=div and alu_b==0: LED<=16'hFFFF, go to S_ERR. No start pulse is issued.
    - Otherwise: alu_start=1 for exactly the next cycle, go to S_RUN.
- S_RUN:
  - busy=1. All button events are ignored and dropped.
  - alu_done is sampled from the cycle after alu_start.
  - On alu_done with alu_err=1: LED<=16'hFFFF, go to S_ERR.
  - On alu_done with alu_err=0: LED<=alu_result, result register<=alu_result, go to S_SHOW.
  - Timeout counter clears on entry. When it reaches TIMEOUT_CYCLES without alu_done: LED<=16'hFFFF, go to S_ERR. A late alu_done arriving after that is ignored.
  - LED updates exactly one cycle after the alu_done cycle.
- S_SHOW:
  - L/R/D/U: rerun with the same operands and the new op; same rules as S_OP.
  - C: alu_a<=sw, LED<=sw, go to S_B.
- S_ERR:
  - LED holds 16'hFFFF. Op events are ignored.
  - C: alu_a<=sw, LED<=sw, go to S_B.
- Register behaviour:
  - alu_a and alu_b hold their values between loads.
  - alu_op holds after start.
  - No arithmetic is done in this block; all widths are 16 bits, passed through.

Optional Feature:
- Macro: CALC_CHAIN_EN.
- Defined: C in S_SHOW performs alu_a<=result register (previous result), alu_b<=sw, LED<=sw, and goes straight to S_OP. This allows chained calculations.
- Undefined: C in S_SHOW behaves as stated above (new A from sw, go to S_B). The result register may be optimized away.

Test Plan (bench uses DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16, behavioural ALU with 3-cycle latency):
- sw=0x0007, press/release C; sw=0x0005, C; then L -> alu_start one pulse with alu_a=7, alu_b=5, alu_op=0; LED=0x000C one cycle after alu_done; state S_SHOW.
- In S_SHOW press R -> new start with op=1; LED=0x0002. Then D -> LED=0x0023.
- Load A=0x0010, B=0x0000, press U -> no alu_start; LED=0xFFFF next cycle. Then C with sw=0x0003 -> LED=0x0003, state S_B.
- ALU model never asserts done -> LED=0xFFFF exactly TIMEOUT_CYCLES after entering S_RUN. A later alu_done causes no LED change. A 2-cycle button glitch (shorter than DEBOUNCE_CYCLES) produces no event.
- Assert CPU_RESETN low during S_RUN -> LED=0, alu_start=0, busy=0 with no clock edge. After release, C with sw=0x1234 -> LED=0x1234.
- CALC_CHAIN_EN defined: 7+5 -> LED=0x000C; sw=0x0002, C -> LED=0x0002, state S_OP; D -> LED=0x0018. L and C released in the same cycle -> only the C action is taken.
